// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: stage enables/clears, load-use/redirect/dmem-wait hazards,
// dmem timeout supervision, halt/drain FSM and EX forwarding. Optional: PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
   parameter int unsigned RFIDX_W      = 5,
   parameter int unsigned MEM_TIMEOUT  = 64,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [RFIDX_W-1:0] rs1D,
   input  logic [RFIDX_W-1:0] rs2D,
   input  logic [RFIDX_W-1:0] rs1E,
   input  logic [RFIDX_W-1:0] rs2E,
   input  logic [RFIDX_W-1:0] rdE,
   input  logic               regwriteE,
   input  logic               memtoregE,
   input  logic               pcsrcE,
   input  logic [RFIDX_W-1:0] rdM,
   input  logic               regwriteM,
   input  logic               dmem_reqM,
   input  logic               dmem_readyM,
   input  logic [RFIDX_W-1:0] rdW,
   input  logic               regwriteW,
   input  logic               halt_req,
   output logic               enF,
   output logic               enD,
   output logic               enE,
   output logic               enM,
   output logic               flushD,
   output logic               flushE,
   output logic               flushW,
   output logic [1:0]         fwdA,
   output logic [1:0]         fwdB,
   output logic               halted,
   output logic               mem_timeout_err,
   output logic [31:0]        stall_cnt,
   output logic [31:0]        flush_cnt
);

   typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

   localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT - 1);
   localparam logic [3:0] DrainLast = 4'(DRAIN_CYCLES - 1);

   state_e           state_q, state_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic [3:0]       drain_q, drain_d;
   logic             err_q, err_d;
   logic             memstall, lduse;

   assign memstall = dmem_reqM & ~dmem_readyM;
   assign lduse    = regwriteE & memtoregE & (rdE != '0) & ((rdE == rs1D) | (rdE == rs2D));

   function automatic logic [1:0] fwd_sel(input logic [RFIDX_W-1:0] rs);
      if (regwriteM && rdM != '0 && rdM == rs)      return 2'b10;
      else if (regwriteW && rdW != '0 && rdW == rs) return 2'b01;
      else                                          return 2'b00;
   endfunction

   assign fwdA = fwd_sel(rs1E);
   assign fwdB = fwd_sel(rs2E);

   always_comb begin
      enF     = 1'b1;
      enD     = 1'b1;
      enE     = 1'b1;
      enM     = 1'b1;
      flushD  = 1'b0;
      flushE  = 1'b0;
      flushW  = 1'b0;
      halted  = 1'b0;
      state_d = state_q;
      drain_d = drain_q;

      unique case (state_q)
         StRun: begin
            if (halt_req && !memstall) begin
               state_d = StDrain;
               drain_d = '0;
            end
         end
         StDrain: begin
            // Fetch frozen; bubbles fill ID until the older instructions retire.
            enF    = 1'b0;
            flushD = 1'b1;
            if (!halt_req) begin
               state_d = StRun;
            end else if (!memstall && !lduse) begin
               if (drain_q == DrainLast) state_d = StHalted;
               else                      drain_d = drain_q + 4'd1;
            end
         end
         StHalted: begin
            enF    = 1'b0;
            enD    = 1'b0;
            enE    = 1'b0;
            enM    = 1'b0;
            flushD = 1'b0;
            halted = 1'b1;
            if (!halt_req) state_d = StRun;
         end
         default: state_d = StRun;
      endcase

      if (state_q != StHalted) begin
         if (memstall) begin
            enF    = 1'b0;
            enD    = 1'b0;
            enE    = 1'b0;
            enM    = 1'b0;
            flushD = 1'b0;
            flushE = 1'b0;
            flushW = 1'b1;
         end else if (pcsrcE) begin
            enF    = 1'b1;
            enD    = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
         end else if (lduse) begin
            enF    = 1'b0;
            enD    = 1'b0;
            flushD = 1'b0;
            flushE = 1'b1;
         end
      end
   end

   always_comb begin
      wait_d = '0;
      err_d  = err_q;
      if (memstall) begin
         wait_d = (wait_q == WaitMax) ? wait_q : wait_q + 1'b1;
         if (wait_q == WaitMax) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StRun;
         wait_q  <= '0;
         drain_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         drain_q <= drain_d;
         err_q   <= err_d;
      end
   end

   assign mem_timeout_err = err_q;

`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] stall_q, flush_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!enF && state_q != StHalted) stall_q <= stall_q + 32'd1;
         if (flushE)                      flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle expected control vectors are queued
// as stimulus is applied and compared once outputs settle.
module tb_pipe_hazard_ctrl;

   localparam int unsigned MemTimeout  = 4;
   localparam int unsigned DrainCycles = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic       regwriteE, memtoregE, pcsrcE, regwriteM, dmem_reqM, dmem_readyM;
   logic       regwriteW, halt_req;
   logic       enF, enD, enE, enM, flushD, flushE, flushW, halted, mem_timeout_err;
   logic [1:0] fwdA, fwdB;
   logic [31:0] stall_cnt, flush_cnt;

   pipe_hazard_ctrl #(
      .RFIDX_W      (5),
      .MEM_TIMEOUT  (MemTimeout),
      .DRAIN_CYCLES (DrainCycles)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .rs1D            (rs1D),
      .rs2D            (rs2D),
      .rs1E            (rs1E),
      .rs2E            (rs2E),
      .rdE             (rdE),
      .regwriteE       (regwriteE),
      .memtoregE       (memtoregE),
      .pcsrcE          (pcsrcE),
      .rdM             (rdM),
      .regwriteM       (regwriteM),
      .dmem_reqM       (dmem_reqM),
      .dmem_readyM     (dmem_readyM),
      .rdW             (rdW),
      .regwriteW       (regwriteW),
      .halt_req        (halt_req),
      .enF             (enF),
      .enD             (enD),
      .enE             (enE),
      .enM             (enM),
      .flushD          (flushD),
      .flushE          (flushE),
      .flushW          (flushW),
      .fwdA            (fwdA),
      .fwdB            (fwdB),
      .halted          (halted),
      .mem_timeout_err (mem_timeout_err),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   always #5 clk = ~clk;

   // {enF,enD,enE,enM, flushD,flushE,flushW, fwdA, fwdB, halted, err}
   logic [12:0] obs;
   assign obs = {enF, enD, enE, enM, flushD, flushE, flushW, fwdA, fwdB, halted,
                 mem_timeout_err};

   localparam logic [12:0] RunV    = 13'b1111_000_00_00_0_0;
   localparam logic [12:0] LduseV  = 13'b0011_010_00_00_0_0;
   localparam logic [12:0] RedirV  = 13'b1111_110_00_00_0_0;
   localparam logic [12:0] MstallV = 13'b0000_001_00_00_0_0;
   localparam logic [12:0] DrainV  = 13'b0111_100_00_00_0_0;
   localparam logic [12:0] HaltV   = 13'b0000_000_00_00_1_0;

   logic [12:0] sb[$];
   logic [12:0] e;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_stall = '0;
   logic [31:0] m_flush = '0;

   task automatic idle();
      {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
      {regwriteE, memtoregE, pcsrcE, regwriteM, dmem_reqM, dmem_readyM} = '0;
      regwriteW = 1'b0;
      halt_req  = 1'b0;
   endtask

   // Advance the counter model by one clocked cycle with the given expected outputs.
   task automatic bump(input logic [12:0] v);
`ifdef PIPE_HAZARD_PERF_EN
      if (!v[12] && !v[1]) m_stall = m_stall + 32'd1;
      if (v[7])            m_flush = m_flush + 32'd1;
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      #1;
      sb.push_back(RunV);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL reset got=%b exp=%b", obs, e);
      end
      checks++;
      if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
      end
      reset = 1'b0;
   endtask

   task automatic test_lduse();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         idle();
         case (c)
            0: begin regwriteE = 1; memtoregE = 1; rdE = 5; rs1D = 5; sb.push_back(LduseV); end
            1: sb.push_back(RunV);
            2: begin regwriteE = 1; memtoregE = 1; rdE = 5; rs2D = 5; sb.push_back(LduseV); end
            default: begin regwriteE = 1; memtoregE = 1; rdE = 0; rs1D = 0; sb.push_back(RunV); end
         endcase
         #1;
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL lduse.c%0d got=%b exp=%b", c, obs, e);
         end
         bump(e);
      end
   endtask

   task automatic test_redirect();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         idle();
         if (c == 0) begin
            pcsrcE = 1; regwriteE = 1; memtoregE = 1; rdE = 9; rs2D = 9;
            sb.push_back(RedirV);
         end else begin
            sb.push_back(RunV);
         end
         #1;
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL redirect.c%0d got=%b exp=%b", c, obs, e);
         end
         bump(e);
      end
      checks++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
         errors++;
         $display("FAIL redirect_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt,
                  m_stall, m_flush);
      end
   endtask

   task automatic test_memstall_redirect();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         idle();
         if (c < 3) begin
            pcsrcE = 1; dmem_reqM = 1; dmem_readyM = 0; sb.push_back(MstallV);
         end else if (c == 3) begin
            pcsrcE = 1; dmem_reqM = 1; dmem_readyM = 1; sb.push_back(RedirV);
         end else begin
            sb.push_back(RunV);
         end
         #1;
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL memstall.c%0d got=%b exp=%b", c, obs, e);
         end
         bump(e);
      end
   endtask

   task automatic test_forwarding();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         idle();
         rdM = 7; rdW = 7; regwriteM = 1; regwriteW = 1; rs1E = 7; rs2E = 0;
         case (c)
            0: sb.push_back(RunV | 13'b0000_000_10_00_0_0);
            1: begin regwriteM = 0; sb.push_back(RunV | 13'b0000_000_01_00_0_0); end
            2: begin rdM = 0; rdW = 0; rs1E = 0; sb.push_back(RunV); end
            default: begin rs1E = 3; rs2E = 7; sb.push_back(RunV | 13'b0000_000_00_10_0_0); end
         endcase
         #1;
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL fwd.c%0d got=%b exp=%b", c, obs, e);
         end
         bump(e);
      end
   endtask

   task automatic test_drain_halt();
      // 0: RUN samples halt_req; 1..5: DRAIN with lduse at 2; 6,7: HALTED; 8: release.
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         idle();
         halt_req = (c < 8);
         if (c == 2) begin regwriteE = 1; memtoregE = 1; rdE = 3; rs1D = 3; end
         if (c == 0 || c == 9)     sb.push_back(RunV);
         else if (c == 2)          sb.push_back(LduseV);
         else if (c < 6)           sb.push_back(DrainV);
         else                      sb.push_back(HaltV);
         #1;
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL drain.c%0d got=%b exp=%b", c, obs, e);
         end
         bump(e);
      end
      checks++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
         errors++;
         $display("FAIL drain_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt,
                  m_stall, m_flush);
      end
   endtask

   task automatic test_drain_abort();
      // Dropping halt_req in DRAIN returns to RUN next cycle.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         idle();
         halt_req = (c == 0);
         sb.push_back((c == 1) ? DrainV : RunV);
         #1;
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL drain_abort.c%0d got=%b exp=%b", c, obs, e);
         end
         bump(e);
      end
      // Asynchronous reset in the middle of DRAIN.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         idle();
         halt_req = 1;
         if (c == 2) begin
            reset = 1'b1;
            m_stall = '0;
            m_flush = '0;
         end
         sb.push_back((c == 0) ? RunV : (c == 1) ? DrainV : RunV);
         #1;
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset_drain.c%0d got=%b exp=%b", c, obs, e);
         end
         if (c != 2) bump(e);
      end
      @(negedge clk);
      idle();
      reset = 1'b0;
   endtask

   task automatic test_timeout();
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         idle();
         if (c < 6) begin
            dmem_reqM = 1;
            sb.push_back(MstallV | ((c >= 4) ? 13'd1 : 13'd0));
         end else begin
            if (c == 8) reset = 1'b1;
            sb.push_back((c == 8) ? RunV : (RunV | 13'd1));
         end
         #1;
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL timeout.c%0d got=%b exp=%b", c, obs, e);
         end
         if (c != 8) bump(e);
      end
      m_stall = '0;
      m_flush = '0;
      checks++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
         errors++;
         $display("FAIL timeout_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt,
                  m_stall, m_flush);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_lduse();
      test_redirect();
      test_memstall_redirect();
      test_forwarding();
      test_drain_halt();
      test_drain_abort();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
